// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus master: request word, FSM state, bus widths.
package mem_bus_pkg;

  localparam int BUS_AW = 8;
  localparam int BUS_DW = 8;

  typedef struct packed {
    logic              we;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
  } bus_req_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/req_fifo.sv
// Request queue for the bus master; extra pointer MSB separates full from empty.
// Head is read combinationally, so a pop takes effect on the same edge as the consumer's capture.
module req_fifo
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_push,
  input  bus_req_t i_push_dat,
  output logic     o_full,
  input  logic     i_pop,
  output logic     o_empty,
  output bus_req_t o_head_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  bus_req_t    r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/mem_bus_master.sv
// Queued single-outstanding memory bus master: IDLE -> SETUP -> ACCESS(xN) -> RESP.
// Push-to-rsp_valid latency is 2 + ACCESS_CYCLES; a stalled response freezes the bus but not the queue.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ACCESS_CYCLES = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [BUS_AW-1:0] req_addr,
  input  logic [BUS_DW-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [BUS_AW-1:0] rsp_addr,
  output logic [BUS_DW-1:0] rsp_rdata,
  output logic [BUS_AW-1:0] bus_addr,
  output logic              bus_rwn,
  output logic [BUS_DW-1:0] bus_wdata,
  input  logic [BUS_DW-1:0] bus_rdata
);

  state_t            r_state;
  bus_req_t          r_hold;
  logic [BUS_DW-1:0] r_rdata;
  logic [3:0]        r_cnt;

  logic     w_full;
  logic     w_empty;
  logic     w_pop;
  logic     w_bus_act;
  bus_req_t w_head;
  bus_req_t w_push_dat;

  assign w_push_dat = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign req_ready  = !w_full;

  req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_push     (req_valid),
    .i_push_dat (w_push_dat),
    .o_full     (w_full),
    .i_pop      (w_pop),
    .o_empty    (w_empty),
    .o_head_dat (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_hold  <= w_head;
            r_rdata <= '0;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_cnt   <= 4'(ACCESS_CYCLES - 1);
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // Read data is only meaningful once the full access time has elapsed.
          if (r_cnt == 4'd0) begin
            if (!r_hold.we) r_rdata <= bus_rdata;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Bus parks as a read of address 0 so a write can never be asserted outside an access.
  assign w_bus_act = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign bus_addr  = w_bus_act ? r_hold.addr  : '0;
  assign bus_rwn   = w_bus_act ? !r_hold.we   : 1'b1;
  assign bus_wdata = w_bus_act ? r_hold.wdata : '0;

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_we    = rsp_valid && r_hold.we;
  assign rsp_addr  = rsp_valid ? r_hold.addr : '0;
  assign rsp_rdata = rsp_valid ? r_rdata     : '0;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench: ACCESS_CYCLES=1 instance on a 256x8 memory model, ACCESS_CYCLES=3 instance on a per-cycle rdata pattern.
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_we, bus_rwn;
  logic [7:0] req_addr, req_wdata, rsp_addr, rsp_rdata, bus_addr, bus_wdata, bus_rdata;

  logic       b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_we, b_bus_rwn;
  logic [7:0] b_req_addr, b_req_wdata, b_rsp_addr, b_rsp_rdata, b_bus_addr, b_bus_wdata, b_bus_rdata;

  mem_bus_master #(.ACCESS_CYCLES(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .bus_addr(bus_addr), .bus_rwn(bus_rwn), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  mem_bus_master #(.ACCESS_CYCLES(3), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_we(b_rsp_we),
    .rsp_addr(b_rsp_addr), .rsp_rdata(b_rsp_rdata),
    .bus_addr(b_bus_addr), .bus_rwn(b_bus_rwn), .bus_wdata(b_bus_wdata), .bus_rdata(b_bus_rdata)
  );

  // Memory contents after reset: mem[a] = a ^ 0x5A.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (!bus_rwn) begin
      mem[bus_addr] <= bus_wdata;
    end
  end
  assign bus_rdata = mem[bus_addr];

  logic [7:0] cyc = 8'd0;
  always @(posedge clk) cyc <= cyc + 8'd1;
  assign b_bus_rdata = cyc ^ 8'hC3;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_a(input logic we, input logic [7:0] a, input logic [7:0] d);
    logic acc;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
    end
    #1 req_valid = 1'b0;
    if (!acc) check("push_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic handshake_a();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, got, held;
    logic [7:0] last_rd;
    logic seen;

    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_rsp_ready = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_we",    32'(rsp_we),    32'd0);
    check("rst_rsp_addr",  32'(rsp_addr),  32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_bus_rwn",   32'(bus_rwn),   32'd1);
    check("rst_bus_addr",  32'(bus_addr),  32'd0);
    check("rst_bus_wdata", 32'(bus_wdata), 32'd0);
    check("rst_b_ready",   32'(b_req_ready), 32'd1);
    rst = 1'b0;

    // Write 0xA5 to 0x3C, then read it back.
    push_a(1'b1, 8'h3C, 8'hA5);
    wait_rsp(lat);
    check("wr_latency", 32'(lat), 32'd3);
    check("wr_rsp_we",  32'(rsp_we), 32'd1);
    check("wr_rsp_addr", 32'(rsp_addr), 32'h3C);
    check("wr_rsp_rdata", 32'(rsp_rdata), 32'd0);
    handshake_a();
    check("wr_rsp_done", 32'(rsp_valid), 32'd0);
    push_a(1'b0, 8'h3C, 8'h00);
    wait_rsp(lat);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_rsp_we",  32'(rsp_we), 32'd0);
    check("rd_rsp_addr", 32'(rsp_addr), 32'h3C);
    check("rd_rsp_rdata", 32'(rsp_rdata), 32'hA5);
    handshake_a();

    // Stall the response and fill the queue: 1 in flight plus 4 queued.
    for (int k = 0; k < 5; k++) begin
      push_a(1'b0, 8'(8'h20 + k), 8'h00);
      check("fill_ready", 32'(req_ready), (k < 4) ? 32'd1 : 32'd0);
    end
    check("stall_valid", 32'(rsp_valid), 32'd1);
    check("stall_addr",  32'(rsp_addr),  32'h20);
    check("stall_rdata", 32'(rsp_rdata), 32'h7A);
    repeat (4) @(posedge clk);
    #1;
    check("stall_valid2", 32'(rsp_valid), 32'd1);
    check("stall_addr2",  32'(rsp_addr),  32'h20);
    check("stall_rdata2", 32'(rsp_rdata), 32'h7A);
    check("stall_ready",  32'(req_ready), 32'd0);
    check("stall_bus_rwn", 32'(bus_rwn), 32'd1);
    check("stall_bus_addr", 32'(bus_addr), 32'd0);
    rsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 80 && got < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        check("drain_addr",  32'(rsp_addr),  32'(8'h20 + got));
        check("drain_rdata", 32'(rsp_rdata), 32'(8'(8'h20 + got) ^ 8'h5A));
        got++;
      end
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("drain_count", 32'(got), 32'd5);
    check("drain_idle",  32'(rsp_valid), 32'd0);

    // Back-to-back traffic through the wrapping queue: write then read-back pairs.
    rsp_ready = 1'b1;
    got = 0;
    fork
      begin
        for (int i = 0; i < 16; i++)
          push_a((i % 2) == 0, 8'(8'h90 + i / 2), 8'(8'hC0 + i));
      end
      begin
        for (int c = 0; c < 400 && got < 16; c++) begin
          @(negedge clk);
          if (rsp_valid) begin
            check("b2b_we",   32'(rsp_we),   ((got % 2) == 0) ? 32'd1 : 32'd0);
            check("b2b_addr", 32'(rsp_addr), 32'(8'h90 + got / 2));
            check("b2b_rdata", 32'(rsp_rdata),
                  ((got % 2) == 0) ? 32'd0 : 32'(8'(8'hC0 + got - 1)));
            got++;
          end
        end
      end
    join
    check("b2b_count", 32'(got), 32'd16);
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    // ACCESS_CYCLES=3: address held SETUP+3 cycles, rdata taken from the last cycle only.
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 8'hFF;
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    held = 0; lat = 0; last_rd = 8'h00;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (b_bus_addr == 8'hFF) begin
        held++;
        last_rd = b_bus_rdata;
      end
      if (b_rsp_valid) begin
        lat = i - 1;
        break;
      end
    end
    check("ac3_held",    32'(held), 32'd4);
    check("ac3_latency", 32'(lat),  32'd5);
    check("ac3_addr",    32'(b_rsp_addr), 32'hFF);
    check("ac3_rdata",   32'(b_rsp_rdata), 32'(last_rd));
    b_rsp_ready = 1'b1;
    @(posedge clk);
    #1 b_rsp_ready = 1'b0;

    // Reset in the middle of a write access, with a push offered on the reset edge.
    push_a(1'b1, 8'h10, 8'h77);
    repeat (2) @(posedge clk);
    #1;
    check("mid_bus_rwn",  32'(bus_rwn),  32'd0);
    check("mid_bus_addr", 32'(bus_addr), 32'h10);
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h55;
    @(posedge clk);
    #1;
    check("abort_bus_rwn",   32'(bus_rwn),   32'd1);
    check("abort_bus_addr",  32'(bus_addr),  32'd0);
    check("abort_bus_wdata", 32'(bus_wdata), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_ready",     32'(req_ready), 32'd1);
    rst = 1'b0;
    req_valid = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    check("abort_ready2", 32'(req_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
